// File: rtl/down_counter.sv
// down_counter: loadable down-counter with IDLE/RUN/PAUSE FSM and a registered terminal-count pulse
// Ports: clk, clear (sync active-high reset), load/load_val (start or reload), en (count enable),
//        count (registered value), tc (one-cycle terminal-count pulse), busy (RUN or PAUSE).
// Optional feature: define AUTO_RELOAD_EN to reload from the stored start value at terminal count.
module down_counter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         en,
  output logic [N-1:0] count,
  output logic         tc,
  output logic         busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  logic [1:0]   state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] reload_q, reload_d;
  logic         tc_q, tc_d;
  logic         busy_q, busy_d;
  logic         active;
  logic         term;
  always_comb begin
    // PAUSE with en high resumes and decrements on the same edge, so it shares the RUN path
    active   = (state_q == RUN || state_q == PAUSE) && en;
    term     = active && count_q == N'(1);
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      state_d  = load_val != '0 ? RUN : IDLE;
      tc_d     = load_val == '0;
    end else if (term) begin
      tc_d    = 1'b1;
`ifdef AUTO_RELOAD_EN
      count_d = reload_q;
      state_d = RUN;
`else
      count_d = '0;
      state_d = IDLE;
`endif
    end else if (active && count_q != '0) begin
      count_d = count_q - N'(1);
      state_d = RUN;
    end else if (state_q == RUN && !en) begin
      state_d = PAUSE;
    end
    // busy is registered from the next state so it falls in the same cycle tc rises
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
    end
  end
  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = busy_q;
endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter: directed self-checking bench for down_counter (N=6), covers both AUTO_RELOAD_EN builds
module tb_down_counter;
`ifdef AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       clear;
  logic       load;
  logic [5:0] load_val;
  logic       en;
  logic [5:0] count;
  logic       tc;
  logic       busy;
  int         errors = 0;
  int         checks = 0;
  down_counter #(.N(6)) dut (
    .clk(clk), .clear(clear), .load(load), .load_val(load_val),
    .en(en), .count(count), .tc(tc), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  initial begin
    clear = 1'b1; load = 1'b1; load_val = 6'd5; en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("clr_count", int'(count), 0);
      check("clr_tc", int'(tc), 0);
      check("clr_busy", int'(busy), 0);
    end
    clear = 1'b0;
    step();
    check("ld5_count", int'(count), 5);
    check("ld5_tc", int'(tc), 0);
    check("ld5_busy", int'(busy), 1);
    load = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      step();
      check("run5_count", int'(count), (c == 5 && AUTO) ? 5 : 5 - c);
      check("run5_tc", int'(tc), int'(c == 5));
      check("run5_busy", int'(busy), int'(AUTO || c != 5));
    end
    step();
    check("after5_count", int'(count), AUTO ? 4 : 0);
    check("after5_tc", int'(tc), 0);
    check("after5_busy", int'(busy), int'(AUTO));
    en = 1'b0;
    step();
    check("idle_en0_count", int'(count), AUTO ? 4 : 0);
    check("idle_en0_tc", int'(tc), 0);
    en = 1'b1;
    load = 1'b1; load_val = 6'd10;
    step();
    load = 1'b0;
    check("ld10_count", int'(count), 10);
    for (int c = 1; c <= 14; c++) begin
      en = !(c >= 4 && c <= 7);
      step();
      check("pause_count", int'(count),
            c <= 3 ? 10 - c : c <= 7 ? 7 : c == 14 ? (AUTO ? 10 : 0) : 14 - c);
      check("pause_tc", int'(tc), int'(c == 14));
      check("pause_busy", int'(busy), int'(AUTO || c != 14));
    end
    en = 1'b1;
    load = 1'b1; load_val = 6'd9;
    step();
    load = 1'b0;
    check("ld9_count", int'(count), 9);
    for (int c = 1; c <= 7; c++) begin
      step();
      check("run9_count", int'(count), 9 - c);
      check("run9_tc", int'(tc), 0);
    end
    load = 1'b1; load_val = 6'd3;
    step();
    load = 1'b0;
    check("reld3_count", int'(count), 3);
    check("reld3_tc", int'(tc), 0);
    for (int c = 1; c <= 3; c++) begin
      step();
      check("run3_count", int'(count), c == 3 ? (AUTO ? 3 : 0) : 3 - c);
      check("run3_tc", int'(tc), int'(c == 3));
    end
    load = 1'b1; load_val = 6'd0;
    step();
    check("ld0_count", int'(count), 0);
    check("ld0_tc", int'(tc), 1);
    check("ld0_busy", int'(busy), 0);
    load = 1'b0;
    step();
    check("ld0_next_tc", int'(tc), 0);
    check("ld0_next_count", int'(count), 0);
    load = 1'b1; load_val = 6'd7;
    step();
    load = 1'b0;
    for (int c = 0; c < 3; c++) step();
    check("pre_clr_count", int'(count), 4);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("midclr_count", int'(count), 0);
    check("midclr_tc", int'(tc), 0);
    check("midclr_busy", int'(busy), 0);
    step();
    check("postclr_tc", int'(tc), 0);
    check("postclr_count", int'(count), 0);
    load = 1'b1; load_val = 6'd5;
    step();
    load = 1'b0; en = 1'b0;
    step();
    check("pause_hold_count", int'(count), 5);
    check("pause_hold_busy", int'(busy), 1);
    clear = 1'b1; load = 1'b1;
    step();
    clear = 1'b0; load = 1'b0; en = 1'b1;
    check("pclr_count", int'(count), 0);
    check("pclr_busy", int'(busy), 0);
    step();
    check("pclr_tc", int'(tc), 0);
    check("pclr_idle_count", int'(count), 0);
    load = 1'b1; load_val = 6'd4;
    step();
    load = 1'b0;
    check("ld4_count", int'(count), 4);
    check("ld4_busy", int'(busy), 1);
    for (int c = 1; c <= 20; c++) begin
      step();
      check("auto_count", int'(count), AUTO ? 4 - (c % 4) : (c < 4 ? 4 - c : 0));
      check("auto_tc", int'(tc), AUTO ? int'(c % 4 == 0) : int'(c == 4));
      check("auto_busy", int'(busy), int'(AUTO || c < 4));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
